weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- Writer side of the parameter-RAM interface that the inference FSM reads (embedding, hidden and logit weights).
- Consumes a framed byte stream from the UART receiver and assembles little-endian 16-bit words.
- Issues request/acknowledge writes to the RAM controller at consecutive word addresses.
- Reports completion, progress and frame errors to the top level (LEDs and hex display).

Parameters:
- ADDR_WIDTH, 27: RAM word-address width; matches the read_address width on the inference side.
- DATA_WIDTH, 16: RAM word width; fixed at two bytes per word.
- COUNT_WIDTH, 16: width of the frame word-count field.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle strobe; rx_data is valid when high.
- write_address  out  ADDR_WIDTH  RAM word address.
- write_data  out  DATA_WIDTH  RAM word.
- write_request  out  1  write request; held until acknowledged.
- write_ack  in  1  RAM controller accepted the current write.
- busy  out  1  high from sync-byte acceptance until the frame ends or aborts.
- done  out  1  one-cycle pulse when a frame completes with a matching checksum.
- error_code  out  2  sticky status: 0 none, 1 checksum mismatch, 2 byte overrun, 3 zero count.
- words_written  out  COUNT_WIDTH  number of words acknowledged in the current or last frame.

Behaviour:
- Frame format, in order:
  - SYNC_BYTE.
  - 4 address bytes, LSB first; bits above ADDR_WIDTH are discarded.
  - 2 count bytes N, LSB first.
  - 2N data bytes, each word low byte first.
  - 1 checksum byte: XOR of every byte after the sync byte, excluding the checksum itself.
- Reset values: write_request 0, write_address 0, write_data 0, busy 0, done 0, error_code 0, words_written 0; state WAIT_SYNC.
- Reset mid-operation drops write_request at once; no partial word is retained.
- States:
  - WAIT_SYNC: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: clear error_code, words_written and the checksum accumulator; set busy; go to ADDR.
  - ADDR: 4 bytes, using a 2-bit byte index; then go to COUNT.
  - COUNT: 2 bytes. If N == 0, set error_code 3, clear busy, go to WAIT_SYNC; no checksum byte is expected. Otherwise go to DATA_LO.
  - DATA_LO: latch the low byte, go to DATA_HI.
  - DATA_HI: form the word and go to WRITE. write_request rises the cycle after the high byte is accepted.
  - WRITE: write_address = base + words_written and write_data are stable while the request is high. On the cycle write_ack is sampled high:
    - drop the request next cycle;
    - increment words_written;
    - go to CHECK if words_written == N, else DATA_LO.
  - CHECK: on the next byte, compare against the accumulator. Match: pulse done. Mismatch: set error_code 1. Either way clear busy and go to WAIT_SYNC.
- Stall buffering:
  - In WRITE, one rx byte is captured into a 1-entry holding register, which is processed the cycle after leaving WRITE.
  - A second rx_valid while the holding register is full sets error_code 2 and discards the byte. The current write still completes (request held until ack); the FSM then returns to WAIT_SYNC, clears busy, and empties the holding register.
- Simultaneous events: if write_ack and rx_valid arrive in the same cycle, the byte goes to the holding register. It is processed the next cycle in DATA_LO or CHECK, with no loss.
- words_written wraps only at N; no address wrap protection (base + N beyond 2^ADDR_WIDTH wraps modulo).
- The checksum accumulator updates on every accepted byte after sync, including held bytes when they are processed.

Decomposition:
- Shared package ml_accel_pkg:
  - loader_state_t enum;
  - error-code constants ERR_NONE, ERR_CHECKSUM, ERR_OVERRUN, ERR_ZERO_COUNT;
  - SYNC_BYTE;
  - VOCAB_SIZE, EMBEDDING_SIZE and LINEAR_SIZE, shared with the inference FSM for address-map constants.
- One sub-module: byte_skid_buffer, the 1-entry holding register with full flag and overrun detect.

Test Plan:
- Basic frame, write_ack 1 cycle after request:
  - Stimulus: A5 30 01 00 00 02 00 34 12 78 56 3B.
  - Response: writes 0x1234 @0x130 then 0x5678 @0x131; done pulses once; error_code 0; words_written 2; busy low afterwards.
- Same frame with checksum 3C:
  - Response: both writes occur; no done; error_code 1.
- Zero count, stimulus A5 00 00 00 00 00 00:
  - Response: no write_request; error_code 3; the next A5 clears error_code to 0.
- Overrun:
  - Stimulus: basic frame with write_ack delayed 6 cycles and bytes every cycle.
  - Response: one byte held; the second byte during the stall gives error_code 2; the first write still completes; state returns to WAIT_SYNC.
- Garbage then frame, with address byte 3 = FF:
  - Stimulus: 00 FF 5A, then a frame with address 30 01 00 FF.
  - Response: garbage ignored; write_address 0x7000130 (top 5 bits dropped).
- Reset low during DATA_HI with write pending:
  - Response: all outputs return to reset values within the same cycle.
  - After reset high: a fresh basic frame completes normally.

Source files
------------

// File: rtl/ml_accel_pkg.sv
// Shared definitions for the accelerator: the weight-loader FSM states,
// the loader status codes, the frame sync marker and the model dimensions
// that the inference FSM uses to lay out its parameter-RAM address map.
package ml_accel_pkg;

    typedef enum logic [2:0] {
        StWaitSync,
        StAddr,
        StCount,
        StDataLo,
        StDataHi,
        StWrite,
        StCheck
    } loader_state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN    = 2'd2;
    localparam logic [1:0] ERR_ZERO_COUNT = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int unsigned VOCAB_SIZE     = 256;
    localparam int unsigned EMBEDDING_SIZE = 32;
    localparam int unsigned LINEAR_SIZE    = 64;

endpackage

// File: rtl/weight_loader_if.sv
// Byte-stream input and RAM write port of the weight loader.
//   rx_data/rx_valid          : byte strobe from the UART receiver
//   write_address/write_data  : RAM word address and word, stable while requesting
//   write_request/write_ack   : request held until the RAM controller acknowledges
// master: the loader side; slave: the UART/RAM-controller side.
interface weight_loader_if #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_request;
    logic                  write_ack;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  write_ack,
        output write_address,
        output write_data,
        output write_request
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output write_ack,
        input  write_address,
        input  write_data,
        input  write_request
    );
endinterface

// File: rtl/byte_skid_buffer.sv
// One-entry byte holding register used while the loader is stalled on a RAM write.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : store a byte
//   pop        : the held byte (dout) is consumed this cycle
//   flush      : discard any held byte (takes priority over push)
//   full       : a byte is held
//   overrun    : push while full without a pop; the pushed byte is dropped
module byte_skid_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       overrun
);
    logic       full_q, full_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        overrun = push && full_q && !pop;
        if (flush) begin
            full_d = 1'b0;
        end else if (push && (!full_q || pop)) begin
            full_d = 1'b1;
            data_d = din;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;
endmodule

// File: rtl/weight_loader.sv
// Weight loader: parses framed bytes (sync, 4-byte base address, 2-byte word count,
// little-endian data words, XOR checksum) and writes the words to consecutive RAM
// addresses over a request/acknowledge port.
//   clk, reset    : clock, asynchronous active-low reset
//   bus           : byte input and RAM write port (master modport)
//   busy          : frame in progress
//   done          : one-cycle pulse on a frame with a good checksum
//   error_code    : sticky status, cleared by the next sync byte
//   words_written : words acknowledged in the current or last frame
module weight_loader #(
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE   = ml_accel_pkg::SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   reset,
    weight_loader_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error_code,
    output logic [COUNT_WIDTH-1:0] words_written
);
    import ml_accel_pkg::*;

    loader_state_t          state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            addr_sr_q, addr_sr_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             csum_q, csum_d;
    logic [ADDR_WIDTH-1:0]  address_q, address_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   request_q, request_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic [1:0]             error_q, error_d;
    logic [COUNT_WIDTH-1:0] written_q, written_d;

    logic       hold_full, hold_pop, hold_push, hold_overrun, hold_flush;
    logic [7:0] hold_data;
    logic       byte_valid;
    logic [7:0] byte_in;

    // A held byte always takes precedence over the live strobe; a live byte that
    // cannot be processed this cycle (stalled, or behind a held byte) is parked.
    assign hold_pop   = hold_full && (state_q != StWrite);
    assign hold_push  = bus.rx_valid && ((state_q == StWrite) || hold_full);
    assign byte_valid = hold_pop || (bus.rx_valid && !hold_full && (state_q != StWrite));
    assign byte_in    = hold_pop ? hold_data : bus.rx_data;

    byte_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .push    (hold_push),
        .pop     (hold_pop),
        .flush   (hold_flush),
        .din     (bus.rx_data),
        .dout    (hold_data),
        .full    (hold_full),
        .overrun (hold_overrun)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_sr_d  = addr_sr_q;
        base_d     = base_q;
        count_d    = count_q;
        lo_d       = lo_q;
        csum_d     = csum_q;
        address_d  = address_q;
        data_d     = data_q;
        request_d  = request_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        error_d    = error_q;
        written_d  = written_q;
        hold_flush = 1'b0;

        // Checksum covers everything between the sync byte and the checksum byte.
        if (byte_valid && (state_q != StWaitSync) && (state_q != StCheck)) begin
            csum_d = csum_q ^ byte_in;
        end

        if (hold_overrun) begin
            error_d   = ERR_OVERRUN;
            overrun_d = 1'b1;
        end

        case (state_q)
            StWaitSync: begin
                if (byte_valid && (byte_in == SYNC_BYTE)) begin
                    error_d   = ERR_NONE;
                    written_d = '0;
                    csum_d    = 8'h00;
                    busy_d    = 1'b1;
                    idx_d     = 2'd0;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (byte_valid) begin
                    // Bytes arrive LSB first, so shift in from the top.
                    addr_sr_d = {byte_in, addr_sr_q[23:8]};
                    idx_d     = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        base_d  = ADDR_WIDTH'({byte_in, addr_sr_q});
                        state_d = StCount;
                    end
                end
            end
            StCount: begin
                if (byte_valid) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd0) begin
                        lo_d = byte_in;
                    end else begin
                        count_d = COUNT_WIDTH'({byte_in, lo_q});
                        idx_d   = 2'd0;
                        if (count_d == '0) begin
                            error_d = ERR_ZERO_COUNT;
                            busy_d  = 1'b0;
                            state_d = StWaitSync;
                        end else begin
                            state_d = StDataLo;
                        end
                    end
                end
            end
            StDataLo: begin
                if (byte_valid) begin
                    lo_d    = byte_in;
                    state_d = StDataHi;
                end
            end
            StDataHi: begin
                if (byte_valid) begin
                    data_d    = DATA_WIDTH'({byte_in, lo_q});
                    address_d = base_q + ADDR_WIDTH'(written_q);
                    request_d = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                if (bus.write_ack) begin
                    request_d = 1'b0;
                    written_d = written_q + COUNT_WIDTH'(1);
                    if (overrun_q || hold_overrun) begin
                        // Frame is abandoned once a byte has been lost.
                        overrun_d  = 1'b0;
                        hold_flush = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = StWaitSync;
                    end else if (written_d == count_q) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataLo;
                    end
                end
            end
            StCheck: begin
                if (byte_valid) begin
                    if (byte_in == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = ERR_CHECKSUM;
                    end
                    busy_d  = 1'b0;
                    state_d = StWaitSync;
                end
            end
            default: begin
                state_d = StWaitSync;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StWaitSync;
            idx_q     <= 2'd0;
            addr_sr_q <= 24'h0;
            base_q    <= '0;
            count_q   <= '0;
            lo_q      <= 8'h00;
            csum_q    <= 8'h00;
            address_q <= '0;
            data_q    <= '0;
            request_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            error_q   <= ERR_NONE;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_sr_q <= addr_sr_d;
            base_q    <= base_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            csum_q    <= csum_d;
            address_q <= address_d;
            data_q    <= data_d;
            request_q <= request_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            error_q   <= error_d;
            written_q <= written_d;
        end
    end

    assign bus.write_address = address_q;
    assign bus.write_data    = data_q;
    assign bus.write_request = request_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error_code        = error_q;
    assign words_written     = written_q;
endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        done;
    logic [1:0]  error_code;
    logic [15:0] words_written;

    weight_loader_if #(.ADDR_WIDTH(27), .DATA_WIDTH(16)) bus ();

    weight_loader #(
        .ADDR_WIDTH  (27),
        .DATA_WIDTH  (16),
        .COUNT_WIDTH (16),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error_code    (error_code),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ack_delay = 1;
    int wait_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  frame_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // RAM controller model: acks after ack_delay request cycles, logs each write.
    initial begin
        bus.write_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.write_ack = 1'b0;
            if (done) done_cnt++;
            if (bus.write_request) begin
                req_cnt++;
                if (wait_cnt >= ack_delay) begin
                    bus.write_ack = 1'b1;
                    wr_addr.push_back(32'(bus.write_address));
                    wr_data.push_back(bus.write_data);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Called at a negedge; with gap 0 consecutive calls give a byte every cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_byte(frame_q[i], gap);
    endtask

    task automatic load_frame(input logic [7:0] csum, input logic [7:0] a3);
        frame_q = {8'hA5, 8'h30, 8'h01, 8'h00, a3, 8'h02, 8'h00,
                   8'h34, 8'h12, 8'h78, 8'h56, csum};
    endtask

    task automatic start_test();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        req_cnt  = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.write_request) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle", {30'd0, busy, bus.write_request}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_two_writes(input string tag, input logic [31:0] base);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], base);
            check({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
            check({tag, "_a1"}, wr_addr[1], base + 32'd1);
            check({tag, "_d1"}, 32'(wr_data[1]), 32'h5678);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(bus.write_request), 32'd0);
        check("rst_addr",  32'(bus.write_address), 32'd0);
        check("rst_data",  32'(bus.write_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(error_code), 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic frame; gap 1 makes a byte coincide with the ack (held path).
        start_test();
        ack_delay = 1;
        load_frame(8'h3B, 8'h00);
        send_frame(0, 11, 1);
        wait_idle();
        check_two_writes("basic", 32'h130);
        check("basic_done",  32'(done_cnt), 32'd1);
        check("basic_err",   32'(error_code), 32'd0);
        check("basic_words", 32'(words_written), 32'd2);

        // Bad checksum
        start_test();
        load_frame(8'h3C, 8'h00);
        send_frame(0, 11, 3);
        wait_idle();
        check_two_writes("csum", 32'h130);
        check("csum_done", 32'(done_cnt), 32'd0);
        check("csum_err",  32'(error_code), 32'd1);

        // Zero count, then a new sync clears the error
        start_test();
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0, 6, 1);
        wait_idle();
        check("zero_req",  32'(req_cnt), 32'd0);
        check("zero_err",  32'(error_code), 32'd3);
        check("zero_busy", 32'(busy), 32'd0);
        send_byte(8'hA5, 0);
        check("resync_err",  32'(error_code), 32'd0);
        check("resync_busy", 32'(busy), 32'd1);
        load_frame(8'h3B, 8'h00);
        send_frame(1, 11, 1);
        wait_idle();
        check("resync_done", 32'(done_cnt), 32'd1);

        // Overrun: bytes every cycle while the first write stalls
        start_test();
        ack_delay = 6;
        load_frame(8'h3B, 8'h00);
        send_frame(0, 11, 0);
        check("ovr_err_early", 32'(error_code), 32'd2);
        wait_idle();
        check("ovr_nwr",   32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("ovr_a0", wr_addr[0], 32'h130);
            check("ovr_d0", 32'(wr_data[0]), 32'h1234);
        end
        check("ovr_err",   32'(error_code), 32'd2);
        check("ovr_done",  32'(done_cnt), 32'd0);
        check("ovr_words", 32'(words_written), 32'd1);
        start_test();
        ack_delay = 1;
        send_frame(0, 11, 2);
        wait_idle();
        check("ovr_after_done", 32'(done_cnt), 32'd1);
        check("ovr_after_err",  32'(error_code), 32'd0);

        // Garbage, then address with top byte FF
        start_test();
        frame_q = {8'h00, 8'hFF, 8'h5A};
        send_frame(0, 2, 1);
        check("garb_busy", 32'(busy), 32'd0);
        load_frame(8'hC4, 8'hFF);
        send_frame(0, 11, 2);
        wait_idle();
        check_two_writes("garb", 32'h7000130);
        check("garb_done", 32'(done_cnt), 32'd1);
        check("garb_err",  32'(error_code), 32'd0);

        // Reset while a write is pending
        start_test();
        ack_delay = 20;
        load_frame(8'h3B, 8'h00);
        send_frame(0, 8, 0);
        check("prerst_req", 32'(bus.write_request), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req",   32'(bus.write_request), 32'd0);
        check("mid_rst_addr",  32'(bus.write_address), 32'd0);
        check("mid_rst_data",  32'(bus.write_data), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_words", 32'(words_written), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ack_delay = 1;
        @(negedge clk);
        start_test();
        send_frame(0, 11, 1);
        wait_idle();
        check_two_writes("post_rst", 32'h130);
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_err",  32'(error_code), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
